// File: rtl/pos_pid_mc.sv
// pos_pid_mc: multi-channel incremental (velocity-form) PID position controller.
// A single multiplier set is time-shared across channels (ERR -> MUL -> SUM per
// channel). Results collect in shadow registers and every channel's DAC code is
// committed on one edge in DONE, so the axes always move together.
module pos_pid_mc #(
   parameter int            CH      = 2,
   parameter int            DW      = 16,
   parameter int            KW      = 16,
   parameter int            FRAC    = 12,
   parameter logic [DW-1:0] DAC_RST = {1'b1, {(DW-1){1'b0}}}
) (
   input  logic             clk_pid,
   input  logic             sys_rst,
   input  logic             start,
   input  logic [CH-1:0]    enable,
   input  logic [CH*KW-1:0] kp,
   input  logic [CH*KW-1:0] ki,
   input  logic [CH*KW-1:0] kd,
   input  logic [CH*DW-1:0] pos_pre,
   input  logic [CH*DW-1:0] pos_adc,
   output logic             busy,
   output logic             dac_valid,
   output logic [CH*DW-1:0] pos_dac,
   output logic [CH-1:0]    sat
);

   localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
   localparam int EW  = DW + 1;        // error width
   localparam int DPW = DW + 3;        // dP / dD width
   localparam int PW  = KW + DW + 4;   // product width
   localparam int AW  = DW + KW + 6;   // accumulator width
   localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);
   localparam logic [DW-1:0] DAC_MAX = {DW{1'b1}};

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ERR  = 3'd1;
   localparam logic [2:0] ST_MUL  = 3'd2;
   localparam logic [2:0] ST_SUM  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   logic [2:0]           state_r, state_nx_s;
   logic [CW-1:0]        ch_r;
   logic                 last_ch_s;

   logic [DW-1:0]        pre_c_r [CH];
   logic [DW-1:0]        adc_c_r [CH];
   logic [KW-1:0]        kp_c_r  [CH];
   logic [KW-1:0]        ki_c_r  [CH];
   logic [KW-1:0]        kd_c_r  [CH];
   logic [CH-1:0]        en_c_r;

   logic signed [EW-1:0] e1_r [CH];
   logic signed [EW-1:0] e2_r [CH];
   logic [DW-1:0]        u1_r     [CH];
   logic [DW-1:0]        shadow_r [CH];
   logic [DW-1:0]        dac_r    [CH];
   logic [CH-1:0]        sat_nx_r, sat_r;
   logic                 busy_r, dac_valid_r;

   logic signed [EW-1:0]  e_s, e_r;
   logic signed [DPW-1:0] e_x_s, e1_x_s, e2_x_s, dp_s, dd_s, dp_r, dd_r;
   logic signed [PW-1:0]  kp_x_s, ki_x_s, kd_x_s, dp_x_s, e_w_s, dd_x_s;
   logic signed [PW-1:0]  p_s, i_s, d_s, p_r, i_r, d_r;
   logic signed [PW-1:0]  p_sh_s, i_sh_s, d_sh_s;
   logic signed [AW-1:0]  acc_s;
   logic [DW-1:0]         clamp_s;
   logic                  clip_s;

   assign last_ch_s = (ch_r == CH_LAST);

   // Next-state logic for the frame sequencer
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_ERR;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ERR:  state_nx_s = ST_MUL;
         ST_MUL:  state_nx_s = ST_SUM;
         ST_SUM: begin
            if (last_ch_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_ERR;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Channel index: cleared on frame accept, advanced after each channel's SUM
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         ch_r <= {CW{1'b0}};
      end else if (state_r == ST_IDLE && start) begin
         ch_r <= {CW{1'b0}};
      end else if (state_r == ST_SUM && !last_ch_s) begin
         ch_r <= ch_r + CW'(1);
      end
   end

   // Snapshot of all frame inputs so later input changes cannot disturb the frame
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         en_c_r <= {CH{1'b0}};
         for (int n = 0; n < CH; n++) begin
            pre_c_r[n] <= {DW{1'b0}};
            adc_c_r[n] <= {DW{1'b0}};
            kp_c_r[n]  <= {KW{1'b0}};
            ki_c_r[n]  <= {KW{1'b0}};
            kd_c_r[n]  <= {KW{1'b0}};
         end
      end else if (state_r == ST_IDLE && start) begin
         en_c_r <= enable;
         for (int n = 0; n < CH; n++) begin
            pre_c_r[n] <= pos_pre[n*DW +: DW];
            adc_c_r[n] <= pos_adc[n*DW +: DW];
            kp_c_r[n]  <= kp[n*KW +: KW];
            ki_c_r[n]  <= ki[n*KW +: KW];
            kd_c_r[n]  <= kd[n*KW +: KW];
         end
      end
   end

   // Error and its first/second differences for the current channel
   always_comb begin
      e_s    = $signed({1'b0, pre_c_r[ch_r]}) - $signed({1'b0, adc_c_r[ch_r]});
      e_x_s  = {{(DPW-EW){e_s[EW-1]}}, e_s};
      e1_x_s = {{(DPW-EW){e1_r[ch_r][EW-1]}}, e1_r[ch_r]};
      e2_x_s = {{(DPW-EW){e2_r[ch_r][EW-1]}}, e2_r[ch_r]};
      dp_s   = e_x_s - e1_x_s;
      dd_s   = e_x_s - (e1_x_s <<< 1) + e2_x_s;
   end

   // Shared multiplier inputs: gains zero-extended, differences sign-extended
   always_comb begin
      kp_x_s = {{(PW-KW){1'b0}}, kp_c_r[ch_r]};
      ki_x_s = {{(PW-KW){1'b0}}, ki_c_r[ch_r]};
      kd_x_s = {{(PW-KW){1'b0}}, kd_c_r[ch_r]};
      dp_x_s = {{(PW-DPW){dp_r[DPW-1]}}, dp_r};
      e_w_s  = {{(PW-EW){e_r[EW-1]}}, e_r};
      dd_x_s = {{(PW-DPW){dd_r[DPW-1]}}, dd_r};
      p_s    = kp_x_s * dp_x_s;
      i_s    = ki_x_s * e_w_s;
      d_s    = kd_x_s * dd_x_s;
   end

   // Pipeline registers: differences in ERR, products in MUL
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         e_r  <= {EW{1'b0}};
         dp_r <= {DPW{1'b0}};
         dd_r <= {DPW{1'b0}};
         p_r  <= {PW{1'b0}};
         i_r  <= {PW{1'b0}};
         d_r  <= {PW{1'b0}};
      end else if (state_r == ST_ERR) begin
         e_r  <= e_s;
         dp_r <= dp_s;
         dd_r <= dd_s;
      end else if (state_r == ST_MUL) begin
         p_r <= p_s;
         i_r <= i_s;
         d_r <= d_s;
      end
   end

   // Accumulate onto the previous clamped output and clamp to the DAC range
   always_comb begin
      p_sh_s = p_r >>> FRAC;
      i_sh_s = i_r >>> FRAC;
      d_sh_s = d_r >>> FRAC;
      acc_s  = {{(AW-DW){1'b0}}, u1_r[ch_r]}
             + {{(AW-PW){p_sh_s[PW-1]}}, p_sh_s}
             + {{(AW-PW){i_sh_s[PW-1]}}, i_sh_s}
             + {{(AW-PW){d_sh_s[PW-1]}}, d_sh_s};
      if (acc_s[AW-1]) begin
         clamp_s = {DW{1'b0}};
         clip_s  = 1'b1;
      end else if (|acc_s[AW-2:DW]) begin
         clamp_s = DAC_MAX;
         clip_s  = 1'b1;
      end else begin
         clamp_s = acc_s[DW-1:0];
         clip_s  = 1'b0;
      end
   end

   // Per-channel loop state; a disabled channel re-seeds from its held output
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         sat_nx_r <= {CH{1'b0}};
         for (int n = 0; n < CH; n++) begin
            e1_r[n]     <= {EW{1'b0}};
            e2_r[n]     <= {EW{1'b0}};
            u1_r[n]     <= DAC_RST;
            shadow_r[n] <= DAC_RST;
         end
      end else if (state_r == ST_SUM) begin
         if (en_c_r[ch_r]) begin
            shadow_r[ch_r] <= clamp_s;
            u1_r[ch_r]     <= clamp_s;
            sat_nx_r[ch_r] <= clip_s;
            e2_r[ch_r]     <= e1_r[ch_r];
            e1_r[ch_r]     <= e_r;
         end else begin
            shadow_r[ch_r] <= dac_r[ch_r];
            u1_r[ch_r]     <= dac_r[ch_r];
            sat_nx_r[ch_r] <= 1'b0;
            e2_r[ch_r]     <= {EW{1'b0}};
            e1_r[ch_r]     <= {EW{1'b0}};
         end
      end
   end

   // Output commit: all channels update together in DONE, valid pulses after
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         sat_r       <= {CH{1'b0}};
         dac_valid_r <= 1'b0;
         for (int n = 0; n < CH; n++) begin
            dac_r[n] <= DAC_RST;
         end
      end else if (state_r == ST_DONE) begin
         sat_r       <= sat_nx_r;
         dac_valid_r <= 1'b1;
         for (int n = 0; n < CH; n++) begin
            dac_r[n] <= shadow_r[n];
         end
      end else begin
         dac_valid_r <= 1'b0;
      end
   end

   // Busy: set on frame accept, held through the cycle after the commit edge
   always_ff @(posedge clk_pid or posedge sys_rst) begin
      if (sys_rst) begin
         busy_r <= 1'b0;
      end else if (state_r == ST_IDLE) begin
         busy_r <= start;
      end else begin
         busy_r <= 1'b1;
      end
   end

   assign busy      = busy_r;
   assign dac_valid = dac_valid_r;
   assign sat       = sat_r;

   for (genvar g = 0; g < CH; g++) begin : g_dac
      assign pos_dac[g*DW +: DW] = dac_r[g];
   end

endmodule

// File: tb/tb_pos_pid_mc.sv
// Self-checking bench for pos_pid_mc (CH=2, DW=16, KW=16, FRAC=12): directed
// vector table, randomized frames against an arithmetic reference model, and
// hand-written handshake / reset-abort sequences.
module tb_pos_pid_mc;
   localparam int CH = 2;
   localparam int DW = 16;
   localparam int KW = 16;
   localparam int FRAC = 12;

   logic             clk_pid = 1'b0;
   logic             sys_rst = 1'b0;
   logic             start = 1'b0;
   logic [CH-1:0]    enable = '0;
   logic [CH*KW-1:0] kp = '0, ki = '0, kd = '0;
   logic [CH*DW-1:0] pos_pre = '0, pos_adc = '0;
   logic             busy, dac_valid;
   logic [CH*DW-1:0] pos_dac;
   logic [CH-1:0]    sat;

   int errors = 0;
   int checks = 0;

   pos_pid_mc #(.CH(CH), .DW(DW), .KW(KW), .FRAC(FRAC)) dut (
      .clk_pid(clk_pid), .sys_rst(sys_rst), .start(start), .enable(enable),
      .kp(kp), .ki(ki), .kd(kd), .pos_pre(pos_pre), .pos_adc(pos_adc),
      .busy(busy), .dac_valid(dac_valid), .pos_dac(pos_dac), .sat(sat)
   );

   always #5 clk_pid = ~clk_pid;

   // ---------------- reference model ----------------
   longint m_e1 [CH];
   longint m_e2 [CH];
   longint m_u1 [CH];
   longint m_dac[CH];
   bit     m_sat[CH];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint fdiv(input longint x);
      longint d;
      longint q;
      d = longint'(1) << FRAC;
      q = x / d;
      if ((x % d != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_e1[c] = 0; m_e2[c] = 0; m_u1[c] = 32768; m_dac[c] = 32768; m_sat[c] = 1'b0;
      end
   endtask

   task automatic model_frame(input logic [CH-1:0] en, input logic [CH*KW-1:0] gp, gi, gd,
                              input logic [CH*DW-1:0] pre, adc);
      longint e, acc, kpv, kiv, kdv, outv;
      for (int c = 0; c < CH; c++) begin
         if (en[c]) begin
            kpv = longint'(gp[c*KW +: KW]);
            kiv = longint'(gi[c*KW +: KW]);
            kdv = longint'(gd[c*KW +: KW]);
            e   = longint'(pre[c*DW +: DW]) - longint'(adc[c*DW +: DW]);
            acc = m_u1[c] + fdiv(kpv * (e - m_e1[c])) + fdiv(kiv * e)
                + fdiv(kdv * (e - 2 * m_e1[c] + m_e2[c]));
            if (acc < 0) begin
               outv = 0; m_sat[c] = 1'b1;
            end else if (acc > 65535) begin
               outv = 65535; m_sat[c] = 1'b1;
            end else begin
               outv = acc; m_sat[c] = 1'b0;
            end
            m_u1[c] = outv; m_e2[c] = m_e1[c]; m_e1[c] = e;
         end else begin
            outv = m_dac[c]; m_u1[c] = m_dac[c];
            m_e1[c] = 0; m_e2[c] = 0; m_sat[c] = 1'b0;
         end
         m_dac[c] = outv;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      @(negedge clk_pid);
      sys_rst = 1'b1;
      start   = 1'b0;
      #1;
      check("rst_dac0", pos_dac[15:0], 32768);
      check("rst_dac1", pos_dac[31:16], 32768);
      check("rst_sat", sat, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", dac_valid, 0);
      @(negedge clk_pid);
      sys_rst = 1'b0;
      model_reset();
   endtask

   // One frame; rel=1 releases a pending reset at the same negedge start is raised.
   task automatic do_frame(input bit rel, input logic [CH-1:0] en_v,
                           input logic [CH*KW-1:0] kp_v, ki_v, kd_v,
                           input logic [CH*DW-1:0] pre_v, adc_v);
      int n;
      bit got;
      @(negedge clk_pid);
      if (rel) begin
         sys_rst = 1'b0;
         model_reset();
      end
      enable = en_v; kp = kp_v; ki = ki_v; kd = kd_v; pos_pre = pre_v; pos_adc = adc_v;
      start = 1'b1;
      @(posedge clk_pid);
      #1;
      start = 1'b0;
      // scramble inputs: the captured frame must not see these
      enable = 2'($urandom); kp = $urandom; ki = $urandom; kd = $urandom;
      pos_pre = $urandom; pos_adc = $urandom;
      model_frame(en_v, kp_v, ki_v, kd_v, pre_v, adc_v);
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk_pid);
         #1;
         n++;
         if (dac_valid) got = 1'b1;
      end
      check("valid_latency", n, 7);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_dac0"}, pos_dac[15:0], m_dac[0]);
      check({tag, "_dac1"}, pos_dac[31:16], m_dac[1]);
      check({tag, "_sat0"}, sat[0], m_sat[0]);
      check({tag, "_sat1"}, sat[1], m_sat[1]);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit         rst;
      logic [1:0] en;
      int kp0, ki0, kd0, pre0, adc0;
      int kp1, ki1, kd1, pre1, adc1;
      int dac0, dac1;
      logic [1:0] sat;
   } vec_t;

   function automatic vec_t mk(input bit r, input logic [1:0] en, input int kp0, ki0, kd0,
                               pre0, adc0, dac0, input bit s0);
      vec_t v;
      v.rst = r; v.en = en; v.kp0 = kp0; v.ki0 = ki0; v.kd0 = kd0; v.pre0 = pre0; v.adc0 = adc0;
      v.kp1 = 0; v.ki1 = 0; v.kd1 = 0; v.pre1 = 32768; v.adc1 = 32768;
      v.dac0 = dac0; v.dac1 = 32768; v.sat = {1'b0, s0};
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      logic [20:0] dv, bz;
      logic [23:0] dvh, bzh;
      int cnt_v, cnt_b;

      // proportional step
      tbl.push_back(mk(1, 2'b11, 4096, 0, 0, 33000, 32768, 33000, 0));
      tbl.push_back(mk(0, 2'b11, 4096, 0, 0, 33000, 32768, 33000, 0));
      // integral ramp
      tbl.push_back(mk(1, 2'b11, 0, 4096, 0, 32868, 32768, 32868, 0));
      tbl.push_back(mk(0, 2'b11, 0, 4096, 0, 32868, 32768, 32968, 0));
      tbl.push_back(mk(0, 2'b11, 0, 4096, 0, 32868, 32768, 33068, 0));
      // derivative: errors 0,100,100,100
      tbl.push_back(mk(1, 2'b11, 0, 0, 4096, 32768, 32768, 32768, 0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 4096, 32868, 32768, 32868, 0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 4096, 32868, 32768, 32768, 0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 4096, 32868, 32768, 32768, 0));
      // saturation high, anti-windup, saturation low
      tbl.push_back(mk(1, 2'b11, 0, 65535, 0, 65535, 32768, 65535, 1));
      tbl.push_back(mk(0, 2'b11, 0, 4096, 0, 32768, 32768, 65535, 0));
      tbl.push_back(mk(0, 2'b11, 0, 65535, 0, 0, 65535, 0, 1));
      // enable drop and bumpless re-entry
      tbl.push_back(mk(1, 2'b11, 4096, 0, 0, 33000, 32768, 33000, 0));
      tbl.push_back(mk(0, 2'b10, 4096, 0, 0, 40000, 32768, 33000, 0));
      tbl.push_back(mk(0, 2'b10, 4096, 0, 0, 33000, 32768, 33000, 0));
      tbl.push_back(mk(0, 2'b11, 4096, 0, 0, 33000, 32768, 33232, 0));
      tbl.push_back(mk(0, 2'b11, 4096, 0, 0, 33000, 32768, 33232, 0));
      // channel 1 exercised independently
      v = mk(1, 2'b11, 0, 0, 0, 32768, 32768, 32768, 0);
      v.kp1 = 4096; v.pre1 = 32000; v.dac1 = 32000;
      tbl.push_back(v);
      v = mk(0, 2'b11, 0, 0, 0, 32768, 32768, 32768, 0);
      v.ki1 = 65535; v.pre1 = 0; v.adc1 = 65535; v.dac1 = 0; v.sat = 2'b10;
      tbl.push_back(v);

      model_reset();
      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         do_frame(1'b0, tbl[i].en,
                  {tbl[i].kp1[15:0], tbl[i].kp0[15:0]},
                  {tbl[i].ki1[15:0], tbl[i].ki0[15:0]},
                  {tbl[i].kd1[15:0], tbl[i].kd0[15:0]},
                  {tbl[i].pre1[15:0], tbl[i].pre0[15:0]},
                  {tbl[i].adc1[15:0], tbl[i].adc0[15:0]});
         check($sformatf("vec%0d_dac0", i), pos_dac[15:0], tbl[i].dac0);
         check($sformatf("vec%0d_dac1", i), pos_dac[31:16], tbl[i].dac1);
         check($sformatf("vec%0d_sat", i), sat, tbl[i].sat);
      end

      // ---------------- randomized frames vs model ----------------
      do_reset();
      for (int f = 0; f < 40; f++) begin
         logic [1:0]  en_v;
         logic [31:0] kp_v, ki_v, kd_v, pre_v, adc_v;
         int t;
         for (int c = 0; c < CH; c++) begin
            en_v[c] = ($urandom_range(0, 4) != 0);
            kp_v[c*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 8192));
            ki_v[c*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 2048));
            kd_v[c*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 8192));
            pre_v[c*16 +: 16] = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) begin
               t = int'(pre_v[c*16 +: 16]) + int'($urandom_range(0, 2000)) - 1000;
               if (t < 0) t = 0;
               if (t > 65535) t = 65535;
               adc_v[c*16 +: 16] = 16'(t);
            end else begin
               adc_v[c*16 +: 16] = 16'($urandom_range(0, 65535));
            end
         end
         do_frame(1'b0, en_v, kp_v, ki_v, kd_v, pre_v, adc_v);
         check_model($sformatf("rnd%0d", f));
      end

      // ---------------- start held high: frame every 8 cycles ----------------
      do_reset();
      start = 1'b1;
      dvh = '0; bzh = '0;
      for (int n = 0; n < 24; n++) begin
         @(posedge clk_pid);
         #1;
         dvh[n] = dac_valid;
         bzh[n] = busy;
      end
      @(negedge clk_pid);
      start = 1'b0;
      check("held_valid_pattern", dvh, 24'h808080);
      check("held_busy_pattern", bzh, 24'hFFFFFF);
      @(posedge clk_pid);
      #1;
      check("held_busy_drop", busy, 0);

      // ---------------- start pulses while busy are ignored ----------------
      @(negedge clk_pid);
      start = 1'b1;
      @(posedge clk_pid);
      #1;
      dv = '0; bz = '0;
      for (int n = 1; n <= 20; n++) begin
         start = (n == 3 || n == 5);
         @(posedge clk_pid);
         #1;
         dv[n] = dac_valid;
         bz[n] = busy;
      end
      start = 1'b0;
      check("busy_ign_valid", dv, 21'h000080);
      check("busy_ign_busy", bz, 21'h0000FE);

      // ---------------- reset abort mid-frame ----------------
      do_reset();
      do_frame(1'b0, 2'b11, 32'h0000_1000, 32'h0, 32'h0, {16'd32768, 16'd33000}, {16'd32768, 16'd32768});
      check("abort_pre_dac0", pos_dac[15:0], 33000);
      @(negedge clk_pid);
      kp = 32'h0000_1000; ki = '0; kd = '0; enable = 2'b11;
      pos_pre = {16'd32768, 16'd40000}; pos_adc = {16'd32768, 16'd32768};
      start = 1'b1;
      @(posedge clk_pid);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk_pid);
      @(posedge clk_pid);
      #1;
      sys_rst = 1'b1;
      #1;
      check("abort_dac0", pos_dac[15:0], 32768);
      check("abort_dac1", pos_dac[31:16], 32768);
      check("abort_busy", busy, 0);
      @(negedge clk_pid);
      sys_rst = 1'b0;
      model_reset();
      cnt_v = 0; cnt_b = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk_pid);
         #1;
         if (dac_valid) cnt_v++;
         if (busy) cnt_b++;
      end
      check("abort_no_valid", cnt_v, 0);
      check("abort_idle", cnt_b, 0);
      check("abort_hold_dac0", pos_dac[15:0], 32768);

      // first start accepted on the first edge after reset release
      @(negedge clk_pid);
      sys_rst = 1'b1;
      do_frame(1'b1, 2'b11, 32'h1000_1000, 32'h0, 32'h0, {16'd32500, 16'd33100}, {16'd32768, 16'd32768});
      check_model("post_rel");
      check("post_rel_dac0", pos_dac[15:0], 33100);
      check("post_rel_dac1", pos_dac[31:16], 32500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
